// File: rtl/da_wave_gen.sv
// Phase-accumulator DAC waveform source: square/saw/triangle/sine, scaled, at sys_clk/CLK_DIV.
// Define DA_WAVE_SINE_EN to build the sine quarter-wave table; otherwise wave 3 yields midscale.
module da_wave_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [1:0]         cfg_wave,
  input  logic [7:0]         cfg_amp,
  output logic               da_clk,
  output logic [7:0]         da_data
);

  localparam int unsigned     CntW    = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               da_clk_q, da_clk_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] freq_q, freq_d, sh_freq_q, sh_freq_d;
  logic [1:0]         wave_q, wave_d, sh_wave_q, sh_wave_d;
  logic [7:0]         amp_q, amp_d, sh_amp_q, sh_amp_d;
  logic               pending_q, pending_d;
  logic               tick_q, scale_en_q;
  logic [7:0]         raw_q, raw_d, scaled_q, scaled_d, da_data_q, da_data_d;

  logic               tick;
  logic [7:0]         p;
  logic [7:0]         raw_val, sine_val, scaled_val;
  logic signed [18:0] s_ext, g_ext, prod;
  logic               unused_prod;

  assign tick      = (cnt_q == CntMax);
  assign p         = acc_q[PHASE_W-1 -: 8];
  assign cfg_ready = !pending_q;
  assign da_clk    = da_clk_q;
  assign da_data   = da_data_q;

`ifdef DA_WAVE_SINE_EN
  // First quadrant of round-half-up(127.5 + 127.5*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [7:0] sine_quarter(input logic [6:0] k);
    logic [7:0] q;
    q = 8'd255;
    case (k)
      7'd0:  q = 8'd128; 7'd1:  q = 8'd131; 7'd2:  q = 8'd134; 7'd3:  q = 8'd137;
      7'd4:  q = 8'd140; 7'd5:  q = 8'd143; 7'd6:  q = 8'd146; 7'd7:  q = 8'd149;
      7'd8:  q = 8'd152; 7'd9:  q = 8'd155; 7'd10: q = 8'd158; 7'd11: q = 8'd162;
      7'd12: q = 8'd165; 7'd13: q = 8'd167; 7'd14: q = 8'd170; 7'd15: q = 8'd173;
      7'd16: q = 8'd176; 7'd17: q = 8'd179; 7'd18: q = 8'd182; 7'd19: q = 8'd185;
      7'd20: q = 8'd188; 7'd21: q = 8'd190; 7'd22: q = 8'd193; 7'd23: q = 8'd196;
      7'd24: q = 8'd198; 7'd25: q = 8'd201; 7'd26: q = 8'd203; 7'd27: q = 8'd206;
      7'd28: q = 8'd208; 7'd29: q = 8'd211; 7'd30: q = 8'd213; 7'd31: q = 8'd215;
      7'd32: q = 8'd218; 7'd33: q = 8'd220; 7'd34: q = 8'd222; 7'd35: q = 8'd224;
      7'd36: q = 8'd226; 7'd37: q = 8'd228; 7'd38: q = 8'd230; 7'd39: q = 8'd232;
      7'd40: q = 8'd234; 7'd41: q = 8'd235; 7'd42: q = 8'd237; 7'd43: q = 8'd238;
      7'd44: q = 8'd240; 7'd45: q = 8'd241; 7'd46: q = 8'd243; 7'd47: q = 8'd244;
      7'd48: q = 8'd245; 7'd49: q = 8'd246; 7'd50: q = 8'd248; 7'd51: q = 8'd249;
      7'd52: q = 8'd250; 7'd53: q = 8'd250; 7'd54: q = 8'd251; 7'd55: q = 8'd252;
      7'd56: q = 8'd253; 7'd57: q = 8'd253; 7'd58: q = 8'd254; 7'd59: q = 8'd254;
      7'd60: q = 8'd254; default: q = 8'd255;
    endcase
    return q;
  endfunction

  logic [6:0] sine_idx;
  logic [7:0] sine_mag;

  // Negative half mirrors as 255-mag, except p=128 where sin is exactly zero.
  always_comb begin
    sine_idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    sine_mag = sine_quarter(sine_idx);
    if (!p[7])              sine_val = sine_mag;
    else if (p[6:0] == '0)  sine_val = 8'h80;
    else                    sine_val = ~sine_mag;
  end
`else
  assign sine_val = 8'h80;
`endif

  always_comb begin
    raw_val = p;
    case (wave_q)
      2'd0:    raw_val = p[7] ? 8'h00 : 8'hFF;
      2'd1:    raw_val = p;
      2'd2:    raw_val = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: raw_val = sine_val;
    endcase
  end

  // (raw-128)*(amp+1) >>> 8, then +128; the result always fits in 8 bits.
  assign s_ext       = $signed({{12{~raw_q[7]}}, raw_q[6:0]});
  assign g_ext       = $signed({10'b0, {1'b0, amp_q} + 9'd1});
  assign prod        = s_ext * g_ext;
  assign scaled_val  = {~prod[15], prod[14:8]};
  assign unused_prod = ^{prod[18:16], prod[7:0]};

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CntW'(1);
    da_clk_d  = (cnt_d >= CntHalf);
    acc_d     = acc_q;
    freq_d    = freq_q;
    wave_d    = wave_q;
    amp_d     = amp_q;
    sh_freq_d = sh_freq_q;
    sh_wave_d = sh_wave_q;
    sh_amp_d  = sh_amp_q;
    pending_d = pending_q;
    da_data_d = da_data_q;

    if (tick) begin
      acc_d     = enable ? acc_q + freq_q : '0;
      da_data_d = enable ? scaled_q : 8'h80;
    end
    if (cfg_valid && !pending_q) begin
      sh_freq_d = cfg_freq;
      sh_wave_d = cfg_wave;
      sh_amp_d  = cfg_amp;
      pending_d = 1'b1;
    end
    // pending_q is only set after the accepting edge, so a same-edge tick does not apply.
    if (tick && pending_q) begin
      freq_d    = sh_freq_q;
      wave_d    = sh_wave_q;
      amp_d     = sh_amp_q;
      pending_d = 1'b0;
    end

    raw_d    = tick_q     ? raw_val    : raw_q;
    scaled_d = scale_en_q ? scaled_val : scaled_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      da_clk_q   <= 1'b0;
      acc_q      <= '0;
      freq_q     <= '0;
      wave_q     <= 2'd1;
      amp_q      <= 8'hFF;
      sh_freq_q  <= '0;
      sh_wave_q  <= 2'd1;
      sh_amp_q   <= 8'hFF;
      pending_q  <= 1'b0;
      tick_q     <= 1'b0;
      scale_en_q <= 1'b0;
      raw_q      <= 8'h80;
      scaled_q   <= 8'h80;
      da_data_q  <= 8'h80;
    end else begin
      cnt_q      <= cnt_d;
      da_clk_q   <= da_clk_d;
      acc_q      <= acc_d;
      freq_q     <= freq_d;
      wave_q     <= wave_d;
      amp_q      <= amp_d;
      sh_freq_q  <= sh_freq_d;
      sh_wave_q  <= sh_wave_d;
      sh_amp_q   <= sh_amp_d;
      pending_q  <= pending_d;
      tick_q     <= tick;
      scale_en_q <= tick_q;
      raw_q      <= raw_d;
      scaled_q   <= scaled_d;
      da_data_q  <= da_data_d;
    end
  end

endmodule

// File: tb/tb_da_wave_gen.sv
// Directed bench for da_wave_gen: reset, divider timing, waveforms, scaling and config handshake.
module tb_da_wave_gen;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned PhaseW = 32;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [PhaseW-1:0] cfg_freq;
  logic [1:0]        cfg_wave;
  logic [7:0]        cfg_amp;
  logic              da_clk;
  logic [7:0]        da_data;

  int n_tests;
  int n_fail;

  da_wave_gen #(
    .CLK_DIV(ClkDiv),
    .PHASE_W(PhaseW)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_freq (cfg_freq),
    .cfg_wave (cfg_wave),
    .cfg_amp  (cfg_amp),
    .da_clk   (da_clk),
    .da_data  (da_data)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns at the falling sys_clk edge just after the next tick (da_clk 1->0).
  task automatic wait_tick();
    logic prev;
    bit   seen;
    prev = da_clk;
    seen = 1'b0;
    for (int i = 0; i < 2 * ClkDiv + 2 && !seen; i++) begin
      @(negedge sys_clk);
      if (prev === 1'b1 && da_clk === 1'b0) seen = 1'b1;
      prev = da_clk;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no da_clk fall within %0d cycles", 2 * ClkDiv + 2);
    end
  endtask

  // Disable, load a config word, wait for it to apply, then re-enable.
  task automatic setup(input logic [PhaseW-1:0] f, input logic [1:0] w, input logic [7:0] a);
    bit ok;
    enable = 1'b0;
    wait_tick();
    cfg_freq  = f;
    cfg_wave  = w;
    cfg_amp   = a;
    cfg_valid = 1'b1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * ClkDiv && !ok; i++) begin
      @(negedge sys_clk);
      if (cfg_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_apply_timeout: cfg_ready=%b expected 1", cfg_ready);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_clk;
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_wave  = 2'd0;
    cfg_amp   = 8'd0;
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (da_data !== 8'h80) begin n_fail++; $display("FAIL rst_da_data: got %02h expected 80", da_data); end
    n_tests++;
    if (da_clk !== 1'b0) begin n_fail++; $display("FAIL rst_da_clk: got %b expected 0", da_clk); end
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
    sys_rst_n = 1'b1;
    wait_tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge sys_clk);
      exp_clk = ((i % ClkDiv) >= ClkDiv / 2);
      n_tests++;
      if (da_clk !== exp_clk) begin
        n_fail++;
        $display("FAIL da_clk_duty%0d: got %b expected %b", i, da_clk, exp_clk);
      end
    end
    enable = 1'b1;
    wait_tick();
    n_tests++;
    if (da_data !== 8'h00) begin n_fail++; $display("FAIL rst_default_saw: got %02h expected 00", da_data); end
    cfg_freq  = '0;
    cfg_wave  = 2'd0;
    cfg_amp   = 8'hFF;
    cfg_valid = 1'b1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_pending: got %b expected 0", cfg_ready); end
    @(negedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if (da_data !== 8'h80) begin n_fail++; $display("FAIL arst_da_data: got %02h expected 80", da_data); end
    n_tests++;
    if (da_clk !== 1'b0) begin n_fail++; $display("FAIL arst_da_clk: got %b expected 0", da_clk); end
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL arst_cfg_ready: got %b expected 1", cfg_ready); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_tick();
    wait_tick();
    n_tests++;
    if (da_data !== 8'h00) begin n_fail++; $display("FAIL rst_cfg_discarded: got %02h expected 00", da_data); end
  endtask

  task automatic test_sawtooth();
    logic [7:0] exp;
    setup(32'h0100_0000, 2'd1, 8'hFF);
    for (int i = 0; i <= 256; i++) begin
      wait_tick();
      exp = 8'(i);
      n_tests++;
      if (da_data !== exp) begin
        n_fail++;
        $display("FAIL saw_step%0d: got %02h expected %02h", i, da_data, exp);
      end
    end
  endtask

  task automatic test_square();
    logic [7:0] exp;
    setup(32'h8000_0000, 2'd0, 8'd127);
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      exp = (i % 2 == 0) ? 8'hBF : 8'h40;
      n_tests++;
      if (da_data !== exp) begin
        n_fail++;
        $display("FAIL square_tick%0d: got %02h expected %02h", i, da_data, exp);
      end
      repeat (2) @(negedge sys_clk);
      n_tests++;
      if (da_data !== exp) begin
        n_fail++;
        $display("FAIL square_hold%0d: got %02h expected %02h", i, da_data, exp);
      end
    end
  endtask

  task automatic test_handshake();
    logic [7:0] tri_exp [4];
    tri_exp = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    enable = 1'b0;
    wait_tick();
    cfg_freq  = '0;
    cfg_wave  = 2'd0;
    cfg_amp   = 8'd0;
    cfg_valid = 1'b1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL hs_low_after_accept: got %b expected 0", cfg_ready); end
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL hs_low_before_tick: got %b expected 0", cfg_ready); end
    @(negedge sys_clk);
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL hs_high_after_tick: got %b expected 1", cfg_ready); end
    // Offer word A so that it is accepted on the tick edge itself, then switch to word B.
    repeat (3) @(negedge sys_clk);
    cfg_freq  = 32'h4000_0000;
    cfg_wave  = 2'd2;
    cfg_amp   = 8'hFF;
    cfg_valid = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL hs_same_edge_low: got %b expected 0", cfg_ready); end
    cfg_freq = 32'h8000_0000;
    cfg_wave = 2'd0;
    cfg_amp  = 8'd127;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk);
      n_tests++;
      if (cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hs_hold_low%0d: got %b expected 0", i, cfg_ready);
      end
    end
    @(negedge sys_clk);
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL hs_same_edge_apply: got %b expected 1", cfg_ready); end
    cfg_valid = 1'b0;
    enable    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      n_tests++;
      if (da_data !== tri_exp[i % 4]) begin
        n_fail++;
        $display("FAIL triangle_tick%0d: got %02h expected %02h", i, da_data, tri_exp[i % 4]);
      end
    end
  endtask

  task automatic test_sine();
    logic [7:0] sin_exp [4];
`ifdef DA_WAVE_SINE_EN
    sin_exp = '{8'h80, 8'hFF, 8'h80, 8'h00};
`else
    sin_exp = '{8'h80, 8'h80, 8'h80, 8'h80};
`endif
    setup(32'h4000_0000, 2'd3, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      n_tests++;
      if (da_data !== sin_exp[i % 4]) begin
        n_fail++;
        $display("FAIL sine_tick%0d: got %02h expected %02h", i, da_data, sin_exp[i % 4]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sawtooth();
    test_square();
    test_handshake();
    test_sine();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
